// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// Holds the FSM encoding and the round-robin pick function.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam int MULT_LATENCY_DEF = 9;
  localparam int NUM_REQ_DEF      = 4;
  localparam int MAX_REQ          = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // Scan from the far end back so the nearest set bit after ptr wins.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int                 n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (req[j]) begin
          p.found = 1'b1;
          p.idx   = 3'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/eight_bit_multiplier.sv
// Sequential shift-add 8x8 unsigned multiplier, one partial product
// per enabled cycle; res is final after eight enabled cycles.
module eight_bit_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] res
);

  logic [15:0] r_acc;
  logic [3:0]  r_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
      r_bit <= '0;
    end else if (en && !r_bit[3]) begin
      if (y[r_bit[2:0]])
        r_acc <= r_acc + ({8'd0, x} << r_bit[2:0]);
      r_bit <= r_bit + 4'd1;
    end
  end

  assign res = r_acc;

endmodule

// File: rtl/mult_rr_picker.sv
// Combinational round-robin selection of one requester,
// starting the search at the registered pointer.
module mult_rr_picker
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_found,
  output logic [ID_W-1:0]    o_idx
);

  logic [MAX_REQ-1:0] w_req;
  pick_t              w_pick;

  always_comb begin
    w_req              = '0;
    w_req[NUM_REQ-1:0] = i_req;
    w_pick             = rr_pick(w_req, 3'(i_ptr), NUM_REQ);
  end

  assign o_found = w_pick.found;
  assign o_idx   = w_pick.idx[ID_W-1:0];

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one sequential multiplier among NUM_REQ clients:
// round-robin grant, restart pulse, fixed-latency run, tagged response.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int MULT_LATENCY = MULT_LATENCY_DEF,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_x,
  input  logic [8*NUM_REQ-1:0] req_y,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_res,
  output logic                 busy,
  output logic                 mult_reset,
  output logic                 mult_en,
  output logic [7:0]           mult_x,
  output logic [7:0]           mult_y,
  input  logic [15:0]          mult_res
);

  localparam int CNT_W = $clog2(MULT_LATENCY + 1);

  state_t             r_state;
  state_t             w_next;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_gid;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_ready;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [15:0]        r_rsp_res;
  logic [7:0]         r_x;
  logic [7:0]         r_y;
  logic               w_found;
  logic [ID_W-1:0]    w_win;

  mult_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_win)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_found) w_next = LOAD;
      LOAD:    w_next = RUN;
      RUN:     if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gid       <= '0;
      r_cnt       <= '0;
      r_ready     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_res   <= '0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      r_state     <= w_next;
      r_ready     <= '0;
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_x     <= req_x[8*w_win +: 8];
            r_y     <= req_y[8*w_win +: 8];
            r_gid   <= w_win;
            r_ready <= NUM_REQ'(1) << w_win;
            r_ptr   <= (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
          end
        end
        LOAD: r_cnt <= CNT_W'(MULT_LATENCY - 1);
        RUN: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_rsp_res   <= mult_res;
            r_rsp_id    <= r_gid;
            r_rsp_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = r_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_res    = r_rsp_res;
  assign busy       = (r_state != IDLE);
  assign mult_reset = reset | (r_state == LOAD);
  assign mult_en    = (r_state == RUN);
  assign mult_x     = r_x;
  assign mult_y     = r_y;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and
// randomized traffic against a round-robin/product reference model.
module tb_mult_share_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 9;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_x, req_y;
  logic [NR-1:0] req_ready;
  logic          rsp_valid;
  logic [IW-1:0] rsp_id;
  logic [15:0]   rsp_res;
  logic          busy, mult_reset, mult_en;
  logic [7:0]    mult_x, mult_y;
  logic [15:0]   mult_res;

  logic [7:0] ox [NR];
  logic [7:0] oy [NR];
  int n_vec = 0;
  int n_err = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_x = '0;
    req_y = '0;
    for (int i = 0; i < NR; i++) begin
      req_x[8*i +: 8] = ox[i];
      req_y[8*i +: 8] = oy[i];
    end
  end

  mult_share_arbiter #(
    .NUM_REQ(NR), .MULT_LATENCY(LAT), .ID_W(IW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_res(rsp_res), .busy(busy),
    .mult_reset(mult_reset), .mult_en(mult_en),
    .mult_x(mult_x), .mult_y(mult_y), .mult_res(mult_res)
  );

  eight_bit_multiplier u_mul (
    .clk(clk), .reset(mult_reset), .en(mult_en),
    .x(mult_x), .y(mult_y), .res(mult_res)
  );

  typedef struct {
    int          id;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [15:0] res;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspid", rsp_id, 0);
    chk("rst_rspres", rsp_res, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en", mult_en, 0);
    chk("rst_mrst", mult_reset, 1);
    chk("rst_mx", mult_x, 0);
    chk("rst_my", mult_y, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_ptr = 0;
  endtask

  // Called at a negedge with the requests already presented.
  task automatic serve(input int eid, input logic [15:0] eres,
                       input logic [NR-1:0] late);
    bit got;
    int k, en_n, rst_n;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready != '0) got = 1;
    end
    if (!got) begin
      chk("ready_timeout", 0, 1);
      req_valid = '0;
      return;
    end
    chk("grant", req_ready, 32'(1) << eid);
    chk("load_mrst", mult_reset, 1);
    chk("load_en", mult_en, 0);
    chk("load_busy", busy, 1);
    chk("op_x", mult_x, ox[eid]);
    chk("op_y", mult_y, oy[eid]);
    req_valid = req_valid & ~req_ready;
    en_n = 0;
    rst_n = 0;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) req_valid = req_valid | late;
      if (rsp_valid) break;
      en_n += int'(mult_en);
      rst_n += int'(mult_reset);
      if (req_ready != '0) chk("stray_ready", req_ready, 0);
      if (!busy) chk("run_busy", busy, 1);
    end
    chk("latency", k, LAT + 1);
    chk("rsp_id", rsp_id, eid);
    chk("rsp_res", rsp_res, eres);
    chk("en_cycles", en_n, LAT);
    chk("mrst_once", rst_n, 0);
    chk("done_en", mult_en, 0);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
    chk("idle_busy", busy, 0);
    m_ptr = (eid + 1) % NR;
  endtask

  function automatic int model_pick(input logic [NR-1:0] v, input int p);
    for (int k = 0; k < NR; k++)
      if (v[(p + k) % NR]) return (p + k) % NR;
    return -1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    int   w;
    logic [NR-1:0] pend;
    tbl = '{
      '{0, 8'd8,   8'd9,   16'd72},
      '{2, 8'd0,   8'd200, 16'd0},
      '{1, 8'd1,   8'd173, 16'd173},
      '{3, 8'd255, 8'd255, 16'd65025},
      '{0, 8'd255, 8'd1,   16'd255},
      '{2, 8'd16,  8'd16,  16'd256}
    };
    for (int i = 0; i < NR; i++) begin ox[i] = 0; oy[i] = 0; end
    reset = 1'b1;
    req_valid = '0;
    #1;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_noreq", busy, 0);

    for (int i = 0; i < 6; i++) begin
      ox[tbl[i].id] = tbl[i].x;
      oy[tbl[i].id] = tbl[i].y;
      req_valid[tbl[i].id] = 1'b1;
      serve(tbl[i].id, tbl[i].res, '0);
    end

    // Two simultaneous requesters from a fresh pointer.
    do_reset();
    ox[1] = 12;  oy[1] = 11;
    ox[3] = 255; oy[3] = 255;
    req_valid = 4'b1010;
    serve(1, 16'd132, '0);
    serve(3, 16'd65025, '0);

    // Everyone persistently requesting.
    do_reset();
    for (int i = 0; i < NR; i++) begin ox[i] = 8'(i + 3); oy[i] = 8'(10 * i + 1); end
    req_valid = '1;
    for (int j = 0; j < 6; j++) begin
      serve(j % NR, 16'((j % NR + 3) * (10 * (j % NR) + 1)), '0);
      req_valid = '1;
    end
    req_valid = '0;

    // Abort in the fourth RUN cycle.
    do_reset();
    ox[2] = 50; oy[2] = 3;
    req_valid = 4'b0100;
    w = 0;
    for (int t = 0; t < 20 && w == 0; t++) begin
      @(negedge clk);
      if (req_ready != '0) w = 1;
    end
    chk("abort_grant", req_ready, 4'b0100);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("abort_inrun", mult_en, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    repeat (2) begin
      @(negedge clk);
      chk("abort_norsp", rsp_valid, 0);
    end
    reset = 1'b0;
    m_ptr = 0;
    ox[0] = 9;  oy[0] = 9;
    ox[2] = 10; oy[2] = 10;
    req_valid = 4'b0101;
    serve(0, 16'd81, '0);
    serve(2, 16'd100, '0);

    // Request appearing mid-job waits for IDLE.
    do_reset();
    ox[0] = 7; oy[0] = 6;
    ox[1] = 3; oy[1] = 5;
    req_valid = 4'b0001;
    serve(0, 16'd42, 4'b0010);
    serve(1, 16'd15, '0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int j = 0; j < 40; j++) begin
      if (req_valid == '0 && $urandom_range(0, 7) == 0) begin
        repeat (3) @(negedge clk);
        chk("rand_idle", {busy, 4'(req_ready)}, 0);
      end
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          ox[i] = ($urandom_range(0, 5) == 0) ? 8'd255 : 8'($urandom);
          oy[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        w = $urandom_range(0, NR - 1);
        ox[w] = 8'($urandom);
        oy[w] = 8'($urandom);
        req_valid[w] = 1'b1;
      end
      pend = req_valid;
      w = model_pick(pend, m_ptr);
      serve(w, 16'(int'(ox[w]) * int'(oy[w])), '0);
    end
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
